// File: rtl/decode_stage.sv
// decode_stage - RV32I decode stage with integrated 32x32 register file.
//
// Decodes the instruction presented by fetch, reads both source operands,
// detects load-use hazards against the instruction in execute and registers
// the result into the ID/EX pipeline register. Writeback writes the register
// file on posedge.
//
// Ports:
//   clk, rst                 clock, synchronous active-high reset
//   inst_fetched_in          instruction from fetch
//   pc_fetched_in            PC of that instruction
//   flush_dec_in             kill the instruction in decode (branch/jump taken)
//   ex_is_load_in, ex_rd_in  load in execute and its destination
//   wb_en_in, wb_rd_in,
//   wb_data_in               register file write port
//   stall_fet_out            combinational hold request to fetch
//   valid_out .. illegal_out ID/EX pipeline register contents
//
// Configuration macro:
//   DECODE_BYPASS_EN  defined: same-cycle write/read of a register returns the
//                     write data. Undefined: the read returns the old value.

module decode_stage #(
  parameter int ARCH_LEN = 32,
  parameter int INST_LEN = 32
) (
  input  logic                clk,
  input  logic                rst,
  input  logic [INST_LEN-1:0] inst_fetched_in,
  input  logic [ARCH_LEN-1:0] pc_fetched_in,
  input  logic                flush_dec_in,
  input  logic                ex_is_load_in,
  input  logic [4:0]          ex_rd_in,
  input  logic                wb_en_in,
  input  logic [4:0]          wb_rd_in,
  input  logic [ARCH_LEN-1:0] wb_data_in,
  output logic                stall_fet_out,
  output logic                valid_out,
  output logic [ARCH_LEN-1:0] pc_out,
  output logic [ARCH_LEN-1:0] rs1_data_out,
  output logic [ARCH_LEN-1:0] rs2_data_out,
  output logic [4:0]          rs1_out,
  output logic [4:0]          rs2_out,
  output logic [4:0]          rd_out,
  output logic [ARCH_LEN-1:0] imm_out,
  output logic [3:0]          alu_op_out,
  output logic [2:0]          funct3_out,
  output logic                use_imm_out,
  output logic                reg_write_out,
  output logic                is_load_out,
  output logic                is_store_out,
  output logic                is_branch_out,
  output logic                is_jal_out,
  output logic                is_jalr_out,
  output logic                is_auipc_out,
  output logic                illegal_out
);

  localparam logic [6:0] OPC_LUI    = 7'b0110111;
  localparam logic [6:0] OPC_AUIPC  = 7'b0010111;
  localparam logic [6:0] OPC_JAL    = 7'b1101111;
  localparam logic [6:0] OPC_JALR   = 7'b1100111;
  localparam logic [6:0] OPC_BRANCH = 7'b1100011;
  localparam logic [6:0] OPC_LOAD   = 7'b0000011;
  localparam logic [6:0] OPC_STORE  = 7'b0100011;
  localparam logic [6:0] OPC_OPIMM  = 7'b0010011;
  localparam logic [6:0] OPC_OP     = 7'b0110011;

  localparam logic [3:0] ALU_ADD  = 4'd0;
  localparam logic [3:0] ALU_SUB  = 4'd1;
  localparam logic [3:0] ALU_SLL  = 4'd2;
  localparam logic [3:0] ALU_SLT  = 4'd3;
  localparam logic [3:0] ALU_SLTU = 4'd4;
  localparam logic [3:0] ALU_XOR  = 4'd5;
  localparam logic [3:0] ALU_SRL  = 4'd6;
  localparam logic [3:0] ALU_SRA  = 4'd7;
  localparam logic [3:0] ALU_OR   = 4'd8;
  localparam logic [3:0] ALU_AND  = 4'd9;
  localparam logic [3:0] ALU_PASS = 4'd10;

  // alt selects SUB/SRA where the encoding allows it
  function automatic logic [3:0] alu_sel(input logic [2:0] f3, input logic alt);
    logic [3:0] op;
    op = ALU_ADD;
    case (f3)
      3'b000: op = alt ? ALU_SUB : ALU_ADD;
      3'b001: op = ALU_SLL;
      3'b010: op = ALU_SLT;
      3'b011: op = ALU_SLTU;
      3'b100: op = ALU_XOR;
      3'b101: op = alt ? ALU_SRA : ALU_SRL;
      3'b110: op = ALU_OR;
      3'b111: op = ALU_AND;
    endcase
    return op;
  endfunction

  logic [31:0] inst;
  logic [6:0]  opcode;
  logic [2:0]  funct3;
  logic [4:0]  rs1, rs2, rd;

  assign inst   = inst_fetched_in[31:0];
  assign opcode = inst[6:0];
  assign funct3 = inst[14:12];
  assign rs1    = inst[19:15];
  assign rs2    = inst[24:20];
  assign rd     = inst[11:7];

  logic signed [31:0] dec_imm;
  logic [3:0]         dec_alu;
  logic [4:0]         dec_rd;
  logic               dec_use_imm, dec_reg_write, dec_load, dec_store, dec_branch;
  logic               dec_jal, dec_jalr, dec_auipc, dec_illegal;
  logic               use_rs1, use_rs2;

  always_comb begin
    dec_imm       = '0;
    dec_alu       = ALU_ADD;
    dec_rd        = rd;
    dec_use_imm   = 1'b0;
    dec_reg_write = 1'b0;
    dec_load      = 1'b0;
    dec_store     = 1'b0;
    dec_branch    = 1'b0;
    dec_jal       = 1'b0;
    dec_jalr      = 1'b0;
    dec_auipc     = 1'b0;
    dec_illegal   = 1'b0;
    use_rs1       = 1'b0;
    use_rs2       = 1'b0;
    case (opcode)
      OPC_LUI: begin
        dec_imm = {inst[31:12], 12'b0};
        dec_alu = ALU_PASS;
        dec_use_imm = 1'b1;
        dec_reg_write = 1'b1;
      end
      OPC_AUIPC: begin
        dec_imm = {inst[31:12], 12'b0};
        dec_use_imm = 1'b1;
        dec_reg_write = 1'b1;
        dec_auipc = 1'b1;
      end
      OPC_JAL: begin
        dec_imm = {{12{inst[31]}}, inst[19:12], inst[20], inst[30:21], 1'b0};
        dec_use_imm = 1'b1;
        dec_reg_write = 1'b1;
        dec_jal = 1'b1;
      end
      OPC_JALR: begin
        dec_imm = {{20{inst[31]}}, inst[31:20]};
        dec_use_imm = 1'b1;
        dec_reg_write = 1'b1;
        dec_jalr = 1'b1;
        use_rs1 = 1'b1;
      end
      OPC_BRANCH: begin
        dec_imm = {{20{inst[31]}}, inst[7], inst[30:25], inst[11:8], 1'b0};
        dec_rd = 5'd0;
        dec_branch = 1'b1;
        use_rs1 = 1'b1;
        use_rs2 = 1'b1;
      end
      OPC_LOAD: begin
        dec_imm = {{20{inst[31]}}, inst[31:20]};
        dec_use_imm = 1'b1;
        dec_reg_write = 1'b1;
        dec_load = 1'b1;
        use_rs1 = 1'b1;
      end
      OPC_STORE: begin
        dec_imm = {{20{inst[31]}}, inst[31:25], inst[11:7]};
        dec_rd = 5'd0;
        dec_use_imm = 1'b1;
        dec_store = 1'b1;
        use_rs1 = 1'b1;
        use_rs2 = 1'b1;
      end
      OPC_OPIMM: begin
        dec_imm = {{20{inst[31]}}, inst[31:20]};
        // no SUBI: inst[30] only distinguishes SRAI from SRLI
        dec_alu = alu_sel(funct3, (funct3 == 3'b101) && inst[30]);
        dec_use_imm = 1'b1;
        dec_reg_write = 1'b1;
        use_rs1 = 1'b1;
      end
      OPC_OP: begin
        dec_alu = alu_sel(funct3, inst[30]);
        dec_reg_write = 1'b1;
        use_rs1 = 1'b1;
        use_rs2 = 1'b1;
      end
      // unknown opcodes read no sources, so they never stall
      default: dec_illegal = 1'b1;
    endcase
  end

  logic hazard, bubble;

  assign hazard = ex_is_load_in && (ex_rd_in != 5'd0) &&
                  ((use_rs1 && (ex_rd_in == rs1)) || (use_rs2 && (ex_rd_in == rs2)));
  assign stall_fet_out = !rst && !flush_dec_in && hazard;
  assign bubble = flush_dec_in || hazard;

  logic [ARCH_LEN-1:0] regs [32];
  logic [ARCH_LEN-1:0] rs1_val, rs2_val;

  always_comb begin
    rs1_val = (rs1 == 5'd0) ? '0 : regs[rs1];
    rs2_val = (rs2 == 5'd0) ? '0 : regs[rs2];
`ifdef DECODE_BYPASS_EN
    if (wb_en_in && (wb_rd_in != 5'd0) && (wb_rd_in == rs1)) rs1_val = wb_data_in;
    if (wb_en_in && (wb_rd_in != 5'd0) && (wb_rd_in == rs2)) rs2_val = wb_data_in;
`endif
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      for (int i = 0; i < 32; i++) regs[i] <= '0;
    end else if (wb_en_in && (wb_rd_in != 5'd0)) begin
      regs[wb_rd_in] <= wb_data_in;
    end
  end

  // a bubble clears the whole ID/EX register, not just valid and flags
  always_ff @(posedge clk) begin
    if (rst || bubble) begin
      valid_out     <= 1'b0;
      pc_out        <= '0;
      rs1_data_out  <= '0;
      rs2_data_out  <= '0;
      rs1_out       <= '0;
      rs2_out       <= '0;
      rd_out        <= '0;
      imm_out       <= '0;
      alu_op_out    <= '0;
      funct3_out    <= '0;
      use_imm_out   <= 1'b0;
      reg_write_out <= 1'b0;
      is_load_out   <= 1'b0;
      is_store_out  <= 1'b0;
      is_branch_out <= 1'b0;
      is_jal_out    <= 1'b0;
      is_jalr_out   <= 1'b0;
      is_auipc_out  <= 1'b0;
      illegal_out   <= 1'b0;
    end else begin
      valid_out     <= 1'b1;
      pc_out        <= pc_fetched_in;
      rs1_data_out  <= rs1_val;
      rs2_data_out  <= rs2_val;
      rs1_out       <= rs1;
      rs2_out       <= rs2;
      rd_out        <= dec_rd;
      imm_out       <= ARCH_LEN'(dec_imm);
      alu_op_out    <= dec_alu;
      funct3_out    <= funct3;
      use_imm_out   <= dec_use_imm;
      reg_write_out <= dec_reg_write;
      is_load_out   <= dec_load;
      is_store_out  <= dec_store;
      is_branch_out <= dec_branch;
      is_jal_out    <= dec_jal;
      is_jalr_out   <= dec_jalr;
      is_auipc_out  <= dec_auipc;
      illegal_out   <= dec_illegal;
    end
  end

endmodule

// File: tb/tb_decode_stage.sv
// tb_decode_stage - self-checking bench for decode_stage.
// Directed cases for the documented scenarios followed by randomized traffic
// checked against a behavioural model of decode, hazard and register file.

module tb_decode_stage;

  logic        clk;
  logic        rst;
  logic [31:0] inst_fetched_in;
  logic [31:0] pc_fetched_in;
  logic        flush_dec_in;
  logic        ex_is_load_in;
  logic [4:0]  ex_rd_in;
  logic        wb_en_in;
  logic [4:0]  wb_rd_in;
  logic [31:0] wb_data_in;
  logic        stall_fet_out;
  logic        valid_out;
  logic [31:0] pc_out, rs1_data_out, rs2_data_out, imm_out;
  logic [4:0]  rs1_out, rs2_out, rd_out;
  logic [3:0]  alu_op_out;
  logic [2:0]  funct3_out;
  logic        use_imm_out, reg_write_out, is_load_out, is_store_out, is_branch_out;
  logic        is_jal_out, is_jalr_out, is_auipc_out, illegal_out;

  decode_stage #(.ARCH_LEN(32), .INST_LEN(32)) dut (
    .clk(clk), .rst(rst),
    .inst_fetched_in(inst_fetched_in), .pc_fetched_in(pc_fetched_in),
    .flush_dec_in(flush_dec_in), .ex_is_load_in(ex_is_load_in), .ex_rd_in(ex_rd_in),
    .wb_en_in(wb_en_in), .wb_rd_in(wb_rd_in), .wb_data_in(wb_data_in),
    .stall_fet_out(stall_fet_out), .valid_out(valid_out), .pc_out(pc_out),
    .rs1_data_out(rs1_data_out), .rs2_data_out(rs2_data_out),
    .rs1_out(rs1_out), .rs2_out(rs2_out), .rd_out(rd_out), .imm_out(imm_out),
    .alu_op_out(alu_op_out), .funct3_out(funct3_out),
    .use_imm_out(use_imm_out), .reg_write_out(reg_write_out),
    .is_load_out(is_load_out), .is_store_out(is_store_out),
    .is_branch_out(is_branch_out), .is_jal_out(is_jal_out),
    .is_jalr_out(is_jalr_out), .is_auipc_out(is_auipc_out),
    .illegal_out(illegal_out)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // flag bit positions in the packed flag vector
  localparam int F_USE_IMM = 8, F_REG_WRITE = 7, F_LOAD = 6, F_STORE = 5, F_BRANCH = 4;
  localparam int F_JAL = 3, F_JALR = 2, F_AUIPC = 1, F_ILLEGAL = 0;

  typedef struct {
    logic [31:0] pc, rs1d, rs2d, imm;
    logic [4:0]  rs1, rs2, rd;
    logic [3:0]  alu;
    logic [2:0]  f3;
    logic [8:0]  flags;
  } exp_t;

  int          n_pass = 0;
  int          n_total = 0;
  logic [31:0] rf [32];
  logic        last_stall;
  int          alu_tab [8] = '{0, 2, 3, 4, 5, 6, 8, 9};
  logic [6:0]  opc_tab [9] = '{7'h37, 7'h17, 7'h6F, 7'h67, 7'h63, 7'h03, 7'h23, 7'h13, 7'h33};

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_total++;
    if (got === exp) n_pass++;
    else $display("FAIL %s: got 0x%08h expected 0x%08h at %0t", tag, got, exp, $time);
  endtask

  function automatic logic [8:0] dut_flags();
    return {use_imm_out, reg_write_out, is_load_out, is_store_out, is_branch_out,
            is_jal_out, is_jalr_out, is_auipc_out, illegal_out};
  endfunction

  // architectural read seen by decode in a cycle with the given writeback
  function automatic logic [31:0] rf_read(input logic [4:0] r, input logic we,
                                          input logic [4:0] wrd, input logic [31:0] wd);
    if (r == 0) return 32'd0;
`ifdef DECODE_BYPASS_EN
    if (we && wrd == r) return wd;
`endif
    return rf[r];
  endfunction

  function automatic void ref_decode(input logic [31:0] in, output exp_t e,
                                     output logic u1, output logic u2);
    int s;
    s = int'(in);
    e.pc = '0; e.rs1d = '0; e.rs2d = '0;
    e.imm = '0; e.alu = 4'd0; e.flags = '0;
    e.rs1 = in[19:15]; e.rs2 = in[24:20]; e.rd = in[11:7]; e.f3 = in[14:12];
    u1 = 1'b0; u2 = 1'b0;
    case (in[6:0])
      7'h37: begin e.imm = s & 32'hFFFFF000; e.alu = 4'd10;
                   e.flags[F_USE_IMM] = 1; e.flags[F_REG_WRITE] = 1; end
      7'h17: begin e.imm = s & 32'hFFFFF000; e.flags[F_AUIPC] = 1;
                   e.flags[F_USE_IMM] = 1; e.flags[F_REG_WRITE] = 1; end
      7'h6F: begin
        e.imm = ((s >>> 31) <<< 20) | (int'(in[19:12]) << 12) | (int'(in[20]) << 11)
              | (int'(in[30:21]) << 1);
        e.flags[F_JAL] = 1; e.flags[F_USE_IMM] = 1; e.flags[F_REG_WRITE] = 1;
      end
      7'h67: begin e.imm = s >>> 20; e.flags[F_JALR] = 1; u1 = 1;
                   e.flags[F_USE_IMM] = 1; e.flags[F_REG_WRITE] = 1; end
      7'h63: begin
        e.imm = ((s >>> 31) <<< 12) | (int'(in[7]) << 11) | (int'(in[30:25]) << 5)
              | (int'(in[11:8]) << 1);
        e.rd = 0; e.flags[F_BRANCH] = 1; u1 = 1; u2 = 1;
      end
      7'h03: begin e.imm = s >>> 20; e.flags[F_LOAD] = 1; u1 = 1;
                   e.flags[F_USE_IMM] = 1; e.flags[F_REG_WRITE] = 1; end
      7'h23: begin e.imm = ((s >>> 25) <<< 5) | int'(in[11:7]); e.rd = 0;
                   e.flags[F_STORE] = 1; e.flags[F_USE_IMM] = 1; u1 = 1; u2 = 1; end
      7'h13: begin
        e.imm = s >>> 20;
        e.alu = 4'(alu_tab[in[14:12]]);
        if (in[14:12] == 3'd5 && in[30]) e.alu = 4'd7;
        e.flags[F_USE_IMM] = 1; e.flags[F_REG_WRITE] = 1; u1 = 1;
      end
      7'h33: begin
        e.alu = 4'(alu_tab[in[14:12]]);
        if (in[30] && in[14:12] == 3'd0) e.alu = 4'd1;
        if (in[30] && in[14:12] == 3'd5) e.alu = 4'd7;
        e.flags[F_REG_WRITE] = 1; u1 = 1; u2 = 1;
      end
      default: e.flags[F_ILLEGAL] = 1;
    endcase
  endfunction

  // One clock cycle: drive, check the combinational stall, clock, check ID/EX.
  task automatic step(input logic r, input logic [31:0] in, input logic [31:0] pc,
                      input logic fl, input logic ld, input logic [4:0] erd,
                      input logic we, input logic [4:0] wrd, input logic [31:0] wd);
    exp_t e;
    logic u1, u2, hz, bub;
    rst = r; inst_fetched_in = in; pc_fetched_in = pc; flush_dec_in = fl;
    ex_is_load_in = ld; ex_rd_in = erd; wb_en_in = we; wb_rd_in = wrd; wb_data_in = wd;
    #1;
    ref_decode(in, e, u1, u2);
    hz = ld && erd != 0 && ((u1 && erd == in[19:15]) || (u2 && erd == in[24:20]));
    last_stall = !r && !fl && hz;
    bub = r || fl || hz;
    check("stall", 32'(stall_fet_out), 32'(last_stall));
    e.pc = pc;
    e.rs1d = rf_read(in[19:15], we, wrd, wd);
    e.rs2d = rf_read(in[24:20], we, wrd, wd);
    @(posedge clk);
    if (r) for (int i = 0; i < 32; i++) rf[i] = '0;
    else if (we && wrd != 0) rf[wrd] = wd;
    #1;
    if (bub) begin
      check("bubble_valid", 32'(valid_out), 32'd0);
      check("bubble_flags", 32'(dut_flags()), 32'd0);
      if (r) begin
        check("rst_pc", pc_out, 32'd0);
        check("rst_rs1d", rs1_data_out, 32'd0);
        check("rst_imm", imm_out, 32'd0);
        check("rst_fields", 32'({rs1_out, rs2_out, rd_out, alu_op_out, funct3_out}), 32'd0);
      end
    end else begin
      check("valid", 32'(valid_out), 32'd1);
      check("pc", pc_out, e.pc);
      check("rs1_data", rs1_data_out, e.rs1d);
      check("rs2_data", rs2_data_out, e.rs2d);
      check("rs1", 32'(rs1_out), 32'(e.rs1));
      check("rs2", 32'(rs2_out), 32'(e.rs2));
      check("rd", 32'(rd_out), 32'(e.rd));
      check("imm", imm_out, e.imm);
      check("alu_op", 32'(alu_op_out), 32'(e.alu));
      check("funct3", 32'(funct3_out), 32'(e.f3));
      check("flags", 32'(dut_flags()), 32'(e.flags));
    end
  endtask

  function automatic logic [31:0] rand_inst();
    logic [31:0] x;
    int k;
    x = $urandom;
    k = $urandom_range(0, 9);
    x[6:0]   = (k == 9) ? 7'($urandom) : opc_tab[k];
    x[11:7]  = 5'($urandom_range(0, 7));
    x[19:15] = 5'($urandom_range(0, 7));
    x[24:20] = 5'($urandom_range(0, 7));
    return x;
  endfunction

  task automatic random_run(input int cycles);
    logic [31:0] cur, pc;
    cur = rand_inst();
    pc = 32'h1000;
    for (int n = 0; n < cycles; n++) begin
      step(1'b0, cur, pc, ($urandom_range(0, 9) == 0), ($urandom_range(0, 2) == 0),
           5'($urandom_range(0, 7)), 1'($urandom_range(0, 1)),
           5'($urandom_range(0, 7)), $urandom);
      if (!last_stall) begin
        cur = rand_inst();
        pc = pc + 32'd4;
      end
    end
  endtask

  initial begin
    #500000;
    $display("FAIL watchdog: simulation did not finish, got timeout expected finish");
    $fatal(1);
  end

  initial begin
    for (int i = 0; i < 32; i++) rf[i] = '0;
    rst = 1'b1; inst_fetched_in = '0; pc_fetched_in = '0; flush_dec_in = 1'b0;
    ex_is_load_in = 1'b0; ex_rd_in = '0; wb_en_in = 1'b0; wb_rd_in = '0; wb_data_in = '0;

    step(1, 32'h00108093, 32'h0, 0, 0, 0, 0, 0, 0);
    step(1, 32'h00108093, 32'h0, 0, 0, 0, 0, 0, 0);

    // addi x1,x1,1
    step(0, 32'h00108093, 32'h0, 0, 0, 0, 0, 0, 0);
    check("addi_valid", 32'(valid_out), 32'd1);
    check("addi_imm", imm_out, 32'h1);
    check("addi_rd", 32'(rd_out), 32'd1);

    // writeback x5 then read it; write x0 then read it
    step(0, 32'h00000013, 32'h4, 0, 0, 0, 1, 5, 32'hDEADBEEF);
    step(0, 32'h00028313, 32'h8, 0, 0, 0, 1, 0, 32'h00001234);
    check("x5_read", rs1_data_out, 32'hDEADBEEF);
    step(0, 32'h00000093, 32'hC, 0, 0, 0, 0, 0, 0);
    check("x0_read", rs1_data_out, 32'h0);

    // load-use on x1 for add x2,x1,x3, then released
    step(0, 32'h00308133, 32'h10, 0, 1, 1, 0, 0, 0);
    check("lu_stall_bubble", 32'(valid_out), 32'd0);
    step(0, 32'h00308133, 32'h10, 0, 0, 1, 0, 0, 0);
    check("lu_release_rd", 32'(rd_out), 32'd2);

    // sw x2,-4(x1)
    step(0, 32'hFE20AE23, 32'h14, 0, 0, 0, 0, 0, 0);
    check("sw_imm", imm_out, 32'hFFFFFFFC);
    check("sw_store", 32'(is_store_out), 32'd1);
    check("sw_rs2", 32'(rs2_out), 32'd2);

    // flush wins over hazard
    step(0, 32'h00308133, 32'h18, 1, 1, 1, 0, 0, 0);
    check("flush_no_stall", 32'(last_stall), 32'(stall_fet_out));

    // illegal opcode
    step(0, 32'h0000007F, 32'h1C, 0, 0, 0, 0, 0, 0);
    check("illegal_flag", 32'(illegal_out), 32'd1);
    check("illegal_nowrite", 32'(reg_write_out), 32'd0);

    // same-cycle writeback and read of x7
    step(0, 32'h00000013, 32'h20, 0, 0, 0, 1, 7, 32'hAAAA5555);
    step(0, 32'h00038413, 32'h24, 0, 0, 0, 1, 7, 32'h12345678);
`ifdef DECODE_BYPASS_EN
    check("x7_same_cycle", rs1_data_out, 32'h12345678);
`else
    check("x7_same_cycle", rs1_data_out, 32'hAAAA5555);
`endif
    step(0, 32'h00038413, 32'h28, 0, 0, 0, 0, 0, 0);
    check("x7_after", rs1_data_out, 32'h12345678);

    random_run(2500);

    // reset mid-run clears the register file even with a write pending
    step(1, rand_inst(), 32'h0, 0, 1, 3, 1, 3, 32'hFFFF0000);
    step(1, rand_inst(), 32'h0, 0, 0, 0, 1, 4, 32'h0000FFFF);
    random_run(500);

    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end

endmodule
